// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
// Module   : counter_ctrl_pkg
// Purpose  : Shared types and constants for the counter step controller.
//            Holds the FSM state encoding, its width, and a small helper
//            that decodes the states where a run is still in progress.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_ctrl_pkg;

  localparam int STATE_W = 2;

  // The encoding is visible on the state output port, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // A run is in progress while stepping or paused.
  function automatic logic is_busy(input ctrl_state_e s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_core.sv
// ============================================================================
// Module   : counter_core
// Purpose  : WIDTH-bit count register with clear / increment / hold control
//            and asynchronous active-low reset. It also exposes the
//            incremented value one bit wider than the count, so the
//            controller can compare it against the terminal count without
//            wrap-around.
// Ports    : clk          in  1        clock
//            rst_n        in  1        async active-low reset
//            clr_i        in  1        clear count to zero (wins over inc_i)
//            inc_i        in  1        increment count by one
//            count_o      out WIDTH    registered count
//            count_inc_o  out WIDTH+1  count_o + 1, unwrapped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH:0]   count_inc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign count_inc_o = {1'b0, count_q} + (WIDTH+1)'(1);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      // The controller never increments past the terminal count, so the
      // carry bit is always zero here.
      count_d = count_inc_o[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/counter_step_ctrl.sv
// ============================================================================
// Module   : counter_step_ctrl
// Purpose  : Sequencer for a shared up-counter: start, pause/resume, abort
//            and a programmable terminal count. Emits a one-cycle done pulse
//            when the count reaches the captured limit. All outputs are
//            registered.
// Ports    : clk     in  1      clock
//            rst_n   in  1      async active-low reset
//            start   in  1      begin a run (IDLE only)
//            limit   in  WIDTH  terminal count, captured on accepted start
//            pause   in  1      freeze count while RUN
//            resume  in  1      continue from PAUSE
//            abort   in  1      cancel run from RUN or PAUSE
//            count   out WIDTH  current count
//            busy    out 1      high in RUN or PAUSE
//            done    out 1      one-cycle pulse in DONE
//            state   out 2      IDLE=0 RUN=1 PAUSE=2 DONE=3
// Config   : COUNTER_STEP_CTRL_SVA_EN - compiles in concurrent assertions on
//            count/limit/done behaviour. Undefined by default.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_step_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   limit,
  input  logic               pause,
  input  logic               resume,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             busy_q;
  logic             done_q;

  logic             w_clr;
  logic             w_inc;
  logic [WIDTH:0]   w_count_inc;

  counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (w_clr),
    .inc_i       (w_inc),
    .count_o     (count),
    .count_inc_o (w_count_inc)
  );

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          limit_d = limit;
          w_clr   = 1'b1;
          // A zero limit is already satisfied by the cleared count.
          state_d = (limit == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          w_clr   = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          w_inc = 1'b1;
          // Compare one bit wider so limit = 2^WIDTH-1 terminates cleanly.
          if (w_count_inc == {1'b0, limit_q}) begin
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_d = IDLE;
          w_clr   = 1'b1;
        end else if (resume) begin
          // The resume cycle itself does not step.
          state_d = RUN;
        end
      end
      DONE: begin
        // Count is left at limit_q until the next accepted start.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // state_q rather than being decoded combinationally from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      busy_q  <= is_busy(state_d);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

`ifdef COUNTER_STEP_CTRL_SVA_EN
  a_run_step: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RUN && !pause && !abort) |=> (count == WIDTH'($past(count) + 1'b1)))
    else $error("counter_step_ctrl: count did not step in RUN");

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count <= limit_q)
    else $error("counter_step_ctrl: count exceeded limit");

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      done |=> !done)
    else $error("counter_step_ctrl: done held longer than one cycle");

  a_pause_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == PAUSE && !resume && !abort) |=> $stable(count))
    else $error("counter_step_ctrl: count moved while paused");
`else
  // No assertion logic in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_step_ctrl.sv
// ============================================================================
// Module   : tb_counter_step_ctrl
// Purpose  : Directed, table-driven bench for counter_step_ctrl (WIDTH=4).
//            Each table row gives the inputs applied before a clock edge and
//            the outputs expected just after it. Asynchronous reset is
//            exercised by a hand-written sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_step_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             pause;
  logic             resume;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  counter_step_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .limit  (limit),
    .pause  (pause),
    .resume (resume),
    .abort  (abort),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic [WIDTH-1:0] limit;
    logic             pause;
    logic             resume;
    logic             abort;
    logic [WIDTH-1:0] ecount;
    logic [1:0]       estate;
    logic             ebusy;
    logic             edone;
  } vec_t;

  vec_t vq[$];
  int   n_checks;
  int   n_fail;

  function automatic void add(input int s, input int l, input int p, input int r,
                              input int a, input int ec, input int es,
                              input int eb, input int ed);
    vec_t v;
    v.start  = 1'(s);
    v.limit  = WIDTH'(l);
    v.pause  = 1'(p);
    v.resume = 1'(r);
    v.abort  = 1'(a);
    v.ecount = WIDTH'(ec);
    v.estate = 2'(es);
    v.ebusy  = 1'(eb);
    v.edone  = 1'(ed);
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ec, input int es,
                         input int eb, input int ed);
    chk({tag, " count"}, int'(count), ec);
    chk({tag, " state"}, int'(state), es);
    chk({tag, " busy"},  int'(busy),  eb);
    chk({tag, " done"},  int'(done),  ed);
  endtask

  task automatic drive(input logic s, input logic [WIDTH-1:0] l, input logic p,
                       input logic r, input logic a);
    start  = s;
    limit  = l;
    pause  = p;
    resume = r;
    abort  = a;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0);

    // ---- vector table: inputs before the edge, outputs after it ----------
    // 1: limit 10, plain run
    add(1, 10, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, k, 1, 1, 0);
    add(0, 0, 0, 0, 0, 10, 3, 0, 1);
    add(0, 0, 0, 0, 0, 10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10, 0, 0, 0);
    // 2: limit 6, pause at 3 for 4 cycles, resume
    add(1, 6, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 0, 0, k, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 0, 3, 2, 1, 0);
    add(0, 0, 0, 1, 0, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 5, 1, 1, 0);
    add(0, 0, 0, 0, 0, 6, 3, 0, 1);
    add(0, 0, 0, 0, 0, 6, 0, 0, 0);
    // 3: limit 8, abort at 5; controls ignored in IDLE
    add(1, 8, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, 0, k, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0, 0, 0);
    // abort out of PAUSE (wins over resume)
    add(1, 7, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 2, 1, 1, 0);
    add(0, 0, 1, 0, 0, 2, 2, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // 4a: limit 0 goes straight to DONE
    add(1, 0, 0, 0, 0, 0, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 4b: limit 15, no wrap
    add(1, 15, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 14; k++) add(0, 0, 0, 0, 0, k, 1, 1, 0);
    add(0, 0, 0, 0, 0, 15, 3, 0, 1);
    add(0, 0, 0, 0, 0, 15, 0, 0, 0);
    // 6: pause+abort together in RUN -> IDLE
    add(1, 5, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    // 6: start held high through RUN and DONE with a changing limit
    add(1, 3, 0, 0, 0, 0, 1, 1, 0);
    add(1, 9, 0, 0, 0, 1, 1, 1, 0);
    add(1, 9, 0, 0, 0, 2, 1, 1, 0);
    add(1, 9, 0, 0, 0, 3, 3, 0, 1);
    add(1, 9, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 0, 0, 0);

    // ---- reset state ------------------------------------------------------
    #1;
    chk_all("reset_noclk", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_clk", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ------------------------------------------------------------
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].start, vq[i].limit, vq[i].pause, vq[i].resume, vq[i].abort);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), int'(vq[i].ecount), int'(vq[i].estate),
              int'(vq[i].ebusy), int'(vq[i].edone));
    end

    // ---- 5: asynchronous reset mid-run at count 4 --------------------------
    @(negedge clk);
    drive(1, 9, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("arst_start", 0, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_all("arst_pre", 4, 1, 1, 0);
    #2;
    rst_n = 1'b0;       // well clear of any clock edge
    #1;
    chk_all("arst_async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("arst_after", 0, 0, 0, 0);

    // A fresh run after reset still terminates at the new limit.
    @(negedge clk);
    drive(1, 2, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst_0", 0, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst_1", 1, 1, 1, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst_2", 2, 3, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
